mash_modulator: RTL

Parametrised MASH 1-1-…-1 delta-sigma modulator for the fractional-N PLL divider. It cascades ORDER first-order accumulator stages, recombines their carries through a differentiator network, and adds the result to an integer divide value. It produces one divide ratio per reference clock for the feedback divider. It is the generalised successor of the fixed third-order modulator: it adds selectable order, integer-part summation, glitch-free word updates, enable/clear control, output saturation and optional dither.

---
 rtl/mash_pkg.sv | 15 +
 rtl/mash_stage.sv | 34 +++
 rtl/mash_modulator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mash_pkg.sv
// Shared constants and helpers for the MASH 1-1-...-1 modulator slice.
package mash_pkg;

   localparam int ORDER_MAX = 4;
   localparam int LFSR_BITS = 15;

   // Fibonacci taps for x^15 + x^14 + 1, as a mask over the shift register
   localparam logic [LFSR_BITS-1:0] LFSR_POLY = 15'h6000;
   localparam logic [LFSR_BITS-1:0] LFSR_SEED = 15'h7FFF;

   function automatic int dn_width(input int order);
      return order + 1;
   endfunction

endpackage

// File: rtl/mash_stage.sv
// One first-order accumulator stage: registered sum and registered carry out.
module mash_stage
   import mash_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            clear,
   input  logic [BITS-1:0] add,
   input  logic            cin,
   output logic [BITS-1:0] sum,
   output logic            carry
);

   logic [BITS:0] total;

   assign total = {1'b0, sum} + {1'b0, add} + {{BITS{1'b0}}, cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum   <= '0;
         carry <= 1'b0;
      end else if (clear) begin
         sum   <= '0;
         carry <= 1'b0;
      end else if (en) begin
         sum   <= total[BITS-1:0];
         carry <= total[BITS];
      end
   end

endmodule

// File: rtl/mash_modulator.sv
// MASH 1-1-...-1 delta-sigma modulator producing one saturated divide ratio per clock.
// Optional dither on the stage-1 carry-in is enabled by defining MASH_DITHER_EN.
module mash_modulator
   import mash_pkg::*;
#(
   parameter int BITS     = 8,
   parameter int ORDER    = 3,
   parameter int INT_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  logic                load,
   input  logic [BITS-1:0]     f_frac,
   input  logic [INT_BITS-1:0] n_int,
   output logic                load_ack,
   output logic [ORDER:0]      dn,
   output logic [INT_BITS:0]   div_out,
   output logic                sat_err
);

   localparam int DW = dn_width(ORDER);

   if (ORDER < 1 || ORDER > ORDER_MAX) begin : g_bad_order
      $error("mash_modulator: ORDER must lie in 1..%0d", ORDER_MAX);
   end

   logic [BITS-1:0]           f_reg;
   logic [INT_BITS-1:0]       n_reg;
   logic [BITS-1:0]           stage_sum [ORDER];
   logic [ORDER-1:0]          stage_carry;
   logic [ORDER-1:0]          aligned;
   logic                      cin;
   logic signed [DW-1:0]      d_level [ORDER+1];
   logic signed [DW-1:0]      d_prev  [ORDER];
   logic signed [INT_BITS+1:0] div_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_reg    <= '0;
         n_reg    <= '0;
         load_ack <= 1'b0;
      end else begin
         load_ack <= load;
         if (load) begin
            f_reg <= f_frac;
            n_reg <= n_int;
         end
      end
   end

`ifdef MASH_DITHER_EN
   logic [LFSR_BITS-1:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (en) begin
         lfsr <= {lfsr[LFSR_BITS-2:0], ^(lfsr & LFSR_POLY)};
      end
   end

   assign cin = lfsr[0];
`else
   assign cin = 1'b0;
`endif

   // Stage k sees stage k-1 one cycle late, so carry k is delayed ORDER-1-k
   // cycles to line every carry up with the last stage before recombination.
   for (genvar k = 0; k < ORDER; k++) begin : g_stage
      localparam int DLY = ORDER - 1 - k;
      logic [BITS-1:0] stage_in;

      if (k == 0) begin : g_first
         assign stage_in = f_reg;
      end else begin : g_next
         assign stage_in = stage_sum[k-1];
      end

      mash_stage #(.BITS(BITS)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .clear (clear),
         .add   (stage_in),
         .cin   ((k == 0) ? cin : 1'b0),
         .sum   (stage_sum[k]),
         .carry (stage_carry[k])
      );

      if (DLY == 0) begin : g_nodly
         assign aligned[k] = stage_carry[k];
      end else begin : g_dly
         logic [DLY-1:0] pipe;
         logic [DLY:0]   shifted;

         assign shifted    = {pipe, stage_carry[k]};
         assign aligned[k] = shifted[DLY];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe <= '0;
            end else if (clear) begin
               pipe <= '0;
            end else if (en) begin
               pipe <= shifted[DLY-1:0];
            end
         end
      end
   end

   // Recursive differentiator: d_k = c_k + (1 - z^-1) d_{k+1}, with d_{ORDER+1} = 0.
   always_comb begin
      d_level[ORDER] = '0;
      for (int k = ORDER - 1; k >= 0; k--) begin
         d_level[k] = $signed({{(DW-1){1'b0}}, aligned[k]}) + d_level[k+1] - d_prev[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ORDER; k++) d_prev[k] <= '0;
         dn <= '0;
      end else if (clear) begin
         for (int k = 0; k < ORDER; k++) d_prev[k] <= '0;
         dn <= '0;
      end else if (en) begin
         for (int k = 0; k < ORDER; k++) d_prev[k] <= d_level[k+1];
         dn <= d_level[0];
      end
   end

   assign div_full = $signed({2'b00, n_reg}) + (INT_BITS+2)'(d_level[0]);

   // Only the low side can clamp: n_reg plus a small dn never exceeds INT_BITS+1 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_out <= '0;
         sat_err <= 1'b0;
      end else if (clear) begin
         sat_err <= 1'b0;
      end else if (en) begin
         if (div_full[INT_BITS+1]) begin
            div_out <= '0;
            sat_err <= 1'b1;
         end else begin
            div_out <= div_full[INT_BITS:0];
         end
      end
   end

endmodule
